// File: rtl/lsu.sv
// lsu: load/store unit running one req/gnt/rvalid data-memory transaction per accepted request.
// Optional LSU_MISALIGN_TRAP_EN traps misaligned H/W accesses instead of ignoring low address bits.
module lsu #(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             is_store,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] store_data,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [3:0]       mem_wstrb,
    input  logic             mem_gnt,
    input  logic             mem_rvalid,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [WIDTH-1:0] load_data,
    output logic             done,
    output logic             busy,
    output logic             err,
    output logic             misalign
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

    state_e           state_q, state_d;
    logic             st_q;
    logic [2:0]       f3_q;
    logic [WIDTH-1:0] addr_q, sd_q, ld_q, ld_d, fmt, wdata;
    logic             err_q, err_d, mis_q, mis_d, illegal, mis_chk;
    logic [31:0]      cnt_q, cnt_d;
    logic [1:0]       o;
    logic [7:0]       b;
    logic [15:0]      h;
    logic [3:0]       wstrb;

    assign illegal = (funct3[1:0] == 2'b11) | (funct3[2] & (funct3[1] | is_store));
`ifdef LSU_MISALIGN_TRAP_EN
    assign mis_chk = !illegal & (((funct3[1:0] == 2'b01) & addr[0]) |
                                 ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00)));
`else
    assign mis_chk = 1'b0;
`endif

    assign o     = addr_q[1:0];
    assign b     = mem_rdata[{o, 3'b000} +: 8];
    assign h     = o[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    assign fmt   = f3_q == 3'b000 ? {{(WIDTH-8){b[7]}}, b} :
                   f3_q == 3'b001 ? {{(WIDTH-16){h[15]}}, h} :
                   f3_q == 3'b100 ? {{(WIDTH-8){1'b0}}, b} :
                   f3_q == 3'b101 ? {{(WIDTH-16){1'b0}}, h} : mem_rdata;
    assign wdata = f3_q[1:0] == 2'b00 ? {4{sd_q[7:0]}} :
                   f3_q[1:0] == 2'b01 ? {2{sd_q[15:0]}} : sd_q;
    assign wstrb = f3_q[1:0] == 2'b00 ? 4'b0001 << o :
                   f3_q[1:0] == 2'b01 ? 4'b0011 << {o[1], 1'b0} : 4'b1111;

    always_comb begin
        state_d = state_q;
        ld_d    = ld_q;
        err_d   = err_q;
        mis_d   = mis_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (req_valid) begin
                ld_d    = '0;
                err_d   = illegal | mis_chk;
                mis_d   = mis_chk;
                state_d = (illegal | mis_chk) ? DONE : REQ;
            end
            REQ: if (mem_gnt) begin
                state_d = st_q ? DONE : WAIT;
                cnt_d   = '0;
            end
            WAIT: if (mem_rvalid) begin
                ld_d    = fmt;
                state_d = DONE;
            end else if (TIMEOUT_CYCLES != 0 && cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
                err_d   = 1'b1;
                state_d = DONE;
            end else begin
                cnt_d   = cnt_q + 32'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            st_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            sd_q    <= '0;
            ld_q    <= '0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ld_q    <= ld_d;
            err_q   <= err_d;
            mis_q   <= mis_d;
            cnt_q   <= cnt_d;
            if (state_q == IDLE && req_valid) begin
                st_q   <= is_store;
                f3_q   <= funct3;
                addr_q <= addr;
                sd_q   <= store_data;
            end
        end
    end

    // Memory-side outputs are forced to zero outside REQ so the bus is quiet between transactions.
    assign req_ready = state_q == IDLE;
    assign busy      = state_q != IDLE;
    assign done      = state_q == DONE;
    assign mem_req   = state_q == REQ;
    assign mem_we    = mem_req & st_q;
    assign mem_addr  = mem_req ? {addr_q[WIDTH-1:2], 2'b00} : '0;
    assign mem_wdata = mem_we ? wdata : '0;
    assign mem_wstrb = mem_we ? wstrb : 4'b0000;
    assign load_data = done ? ld_q : '0;
    assign err       = done & err_q;
    assign misalign  = done & mis_q;
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: table-driven self-checking bench for lsu with a done-side scoreboard and reset corner cases.
module tb_lsu;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req_valid = 1'b0, is_store = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = '0, store_data = '0;
    logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        req_ready, mem_req, mem_we, done, busy, err, misalign;
    logic [31:0] mem_addr, mem_wdata, load_data;
    logic [3:0]  mem_wstrb;

    always #5 clk = ~clk;

    lsu #(.WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .is_store(is_store), .funct3(funct3), .addr(addr), .store_data(store_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .load_data(load_data), .done(done), .busy(busy), .err(err), .misalign(misalign)
    );

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr, sd, rdata;
        int          gd, rd;
        logic        bad;
        logic [31:0] maddr, wdata;
        logic [3:0]  wstrb;
        logic [31:0] ld;
        logic        err, mis;
    } vec_t;

    typedef struct {
        logic [31:0] ld;
        logic        err, mis;
    } exp_t;

    int   errors = 0, checks = 0;
    exp_t sb[$];
    vec_t vt[$];
    localparam logic [31:0] R = 32'h1234_80FF;
    localparam logic [31:0] Q = 32'hFEDC_0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (sb.size() == 0) chk("spurious_done", 32'(done), 32'd0);
            else begin
                e = sb.pop_front();
                chk("load_data", load_data, e.ld);
                chk("err", 32'(err), 32'(e.err));
                chk("misalign", 32'(misalign), 32'(e.mis));
            end
        end else begin
            chk("quiet_outputs", load_data | {30'b0, err, misalign}, 32'd0);
        end
    end

    task automatic run(input vec_t v);
        int   idx, lat, gi;
        bit   fin, exp_req;
        exp_t e;
        e.ld = v.ld; e.err = v.err; e.mis = v.mis;
        lat = v.bad ? 1 : v.st ? 2 + v.gd : v.rd < 0 ? 10 + v.gd : 2 + v.gd + v.rd;
        gi  = 1 + v.gd;
        @(negedge clk);
        req_valid = 1'b1; is_store = v.st; funct3 = v.f3; addr = v.addr; store_data = v.sd;
        sb.push_back(e);
        idx = 0; fin = 0;
        for (int c = 0; c < 40 && !fin; c++) begin
            @(negedge clk);
            idx++;
            if (done) begin
                chk("latency", idx, lat);
                fin = 1;
                req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
            end else begin
                chk("busy_ready", {30'b0, busy, req_ready}, 32'd2);
                exp_req = !v.bad && idx <= gi;
                chk("mem_req", 32'(mem_req), 32'(exp_req));
                if (exp_req) begin
                    chk("mem_addr", mem_addr, v.maddr);
                    chk("mem_we", 32'(mem_we), 32'(v.st));
                    if (v.st) begin
                        chk("mem_wdata", mem_wdata, v.wdata);
                        chk("mem_wstrb", 32'(mem_wstrb), 32'(v.wstrb));
                    end
                end else begin
                    chk("mem_idle", mem_addr | mem_wdata | {28'b0, mem_wstrb} | {31'b0, mem_we}, 32'd0);
                end
                // rvalid with corrupt data in the grant cycle must be ignored
                mem_gnt    = exp_req && idx == gi;
                mem_rvalid = mem_gnt || (!v.st && v.rd >= 0 && idx == gi + v.rd);
                mem_rdata  = (!mem_gnt && idx == gi + v.rd) ? v.rdata : ~v.rdata;
                req_valid  = 1'b1;
                is_store   = 1'($urandom);
                funct3     = 3'($urandom);
                addr       = $urandom;
                store_data = $urandom;
            end
        end
        if (!fin) begin
            chk("done_timeout", 32'(fin), 32'd1);
            req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
            sb.delete();
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        vt.push_back('{1'b1, 3'd0, 32'h1003, 32'h000000A5, R, 0, 0, 1'b0, 32'h1000, 32'hA5A5A5A5, 4'b1000, 32'h0, 1'b0, 1'b0});
        vt.push_back('{1'b0, 3'd0, 32'h2001, 32'h0, R, 0, 3, 1'b0, 32'h2000, 32'h0, 4'b0, 32'hFFFFFF80, 1'b0, 1'b0});
        vt.push_back('{1'b0, 3'd4, 32'h2001, 32'h0, R, 0, 3, 1'b0, 32'h2000, 32'h0, 4'b0, 32'h00000080, 1'b0, 1'b0});
        vt.push_back('{1'b0, 3'd5, 32'h2002, 32'h0, R, 0, 2, 1'b0, 32'h2000, 32'h0, 4'b0, 32'h00001234, 1'b0, 1'b0});
        vt.push_back('{1'b0, 3'd1, 32'h2000, 32'h0, R, 1, 1, 1'b0, 32'h2000, 32'h0, 4'b0, 32'hFFFF80FF, 1'b0, 1'b0});
        vt.push_back('{1'b0, 3'd2, 32'h2004, 32'h0, R, 2, 1, 1'b0, 32'h2004, 32'h0, 4'b0, R, 1'b0, 1'b0});
        vt.push_back('{1'b0, 3'd4, 32'h2003, 32'h0, R, 0, 1, 1'b0, 32'h2000, 32'h0, 4'b0, 32'h00000012, 1'b0, 1'b0});
        vt.push_back('{1'b0, 3'd0, 32'h2000, 32'h0, R, 0, 1, 1'b0, 32'h2000, 32'h0, 4'b0, 32'hFFFFFFFF, 1'b0, 1'b0});
        vt.push_back('{1'b0, 3'd1, 32'h2002, 32'h0, Q, 0, 1, 1'b0, 32'h2000, 32'h0, 4'b0, 32'hFFFFFEDC, 1'b0, 1'b0});
        vt.push_back('{1'b0, 3'd5, 32'h2002, 32'h0, Q, 0, 1, 1'b0, 32'h2000, 32'h0, 4'b0, 32'h0000FEDC, 1'b0, 1'b0});
        vt.push_back('{1'b1, 3'd1, 32'h40, 32'hDEADBEEF, R, 0, 0, 1'b0, 32'h40, 32'hBEEFBEEF, 4'b0011, 32'h0, 1'b0, 1'b0});
        vt.push_back('{1'b1, 3'd1, 32'h42, 32'hDEADBEEF, R, 1, 0, 1'b0, 32'h40, 32'hBEEFBEEF, 4'b1100, 32'h0, 1'b0, 1'b0});
        vt.push_back('{1'b1, 3'd2, 32'h44, 32'hCAFEF00D, R, 4, 0, 1'b0, 32'h44, 32'hCAFEF00D, 4'b1111, 32'h0, 1'b0, 1'b0});
        vt.push_back('{1'b1, 3'd0, 32'h11, 32'h0000003C, R, 0, 0, 1'b0, 32'h10, 32'h3C3C3C3C, 4'b0010, 32'h0, 1'b0, 1'b0});
        vt.push_back('{1'b0, 3'd3, 32'h2000, 32'h0, R, 0, 1, 1'b1, 32'h0, 32'h0, 4'b0, 32'h0, 1'b1, 1'b0});
        vt.push_back('{1'b1, 3'd5, 32'h2000, 32'h1234, R, 0, 0, 1'b1, 32'h0, 32'h0, 4'b0, 32'h0, 1'b1, 1'b0});
        vt.push_back('{1'b0, 3'd7, 32'h2000, 32'h0, R, 0, 1, 1'b1, 32'h0, 32'h0, 4'b0, 32'h0, 1'b1, 1'b0});
        vt.push_back('{1'b0, 3'd2, 32'h50, 32'h0, R, 0, -1, 1'b0, 32'h50, 32'h0, 4'b0, 32'h0, 1'b1, 1'b0});
`ifdef LSU_MISALIGN_TRAP_EN
        vt.push_back('{1'b0, 3'd2, 32'h3002, 32'h0, R, 0, 1, 1'b1, 32'h0, 32'h0, 4'b0, 32'h0, 1'b1, 1'b1});
        vt.push_back('{1'b0, 3'd1, 32'h2003, 32'h0, R, 0, 1, 1'b1, 32'h0, 32'h0, 4'b0, 32'h0, 1'b1, 1'b1});
        vt.push_back('{1'b1, 3'd2, 32'h47, 32'h89ABCDEF, R, 0, 0, 1'b1, 32'h0, 32'h0, 4'b0, 32'h0, 1'b1, 1'b1});
`else
        vt.push_back('{1'b0, 3'd2, 32'h3002, 32'h0, R, 0, 1, 1'b0, 32'h3000, 32'h0, 4'b0, R, 1'b0, 1'b0});
        vt.push_back('{1'b0, 3'd1, 32'h2003, 32'h0, R, 0, 1, 1'b0, 32'h2000, 32'h0, 4'b0, 32'h00001234, 1'b0, 1'b0});
        vt.push_back('{1'b1, 3'd2, 32'h47, 32'h89ABCDEF, R, 0, 0, 1'b0, 32'h44, 32'h89ABCDEF, 4'b1111, 32'h0, 1'b0, 1'b0});
`endif
        foreach (vt[i]) run(vt[i]);

        // async reset while REQ is stalled on gnt drops mem_req without a clock edge
        @(negedge clk);
        req_valid = 1'b1; is_store = 1'b1; funct3 = 3'd2; addr = 32'h80; store_data = 32'h5;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rq_mem_req", 32'(mem_req), 32'd1);
        #1 rst_n = 1'b0;
        #1 chk("rq_rst_mem_req", 32'(mem_req), 32'd0);
        chk("rq_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // async reset in WAIT; a late rvalid must not produce done
        @(negedge clk);
        req_valid = 1'b1; is_store = 1'b0; funct3 = 3'd2; addr = 32'h60;
        @(negedge clk);
        req_valid = 1'b0;
        chk("wt_mem_req", 32'(mem_req), 32'd1);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        chk("wt_busy", 32'(busy), 32'd1);
        #1 rst_n = 1'b0;
        #1 chk("wt_rst_busy", 32'(busy), 32'd0);
        chk("wt_rst_mem_req", 32'(mem_req), 32'd0);
        chk("wt_rst_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = R;
        @(negedge clk);
        mem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("late_rvalid_done", 32'(done), 32'd0);
            chk("late_rvalid_busy", 32'(busy), 32'd0);
        end

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
